load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with alignment, legality and timeout faults
module load_store_unit #(
    parameter int unsigned RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        MemReqValid,
    input  logic        MemReqReady,
    output logic [31:0] MemAddr,
    output logic        MemWe,
    output logic [31:0] MemWData,
    output logic [3:0]  MemWStrb,
    input  logic        MemRspValid,
    input  logic [31:0] MemRData,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic        Busy,
    output logic        Fault,
    output logic [1:0]  FaultCause
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        is_load;
    logic [2:0]  f3;
    logic [1:0]  off;

    logic        illegal;
    logic        misaligned;
    logic [31:0] st_data;
    logic [3:0]  st_strb;

    // Request decode works on the live inputs; it is only consumed in IDLE.
    always_comb begin
        illegal = (MemRead == MemWrite)
               || (MemRead  && (Funct3 == 3'b011 || Funct3[2:1] == 2'b11))
               || (MemWrite && (Funct3 > 3'b010));
        misaligned = (Funct3[1:0] == 2'b01 && ALUResult[0])
                  || (Funct3[1:0] == 2'b10 && ALUResult[1:0] != 2'b00);
        st_data = WriteData;
        st_strb = 4'b1111;
        case (Funct3[1:0])
            2'b00: begin
                st_data = {4{WriteData[7:0]}};
                st_strb = 4'b0001 << ALUResult[1:0];
            end
            2'b01: begin
                st_data = {2{WriteData[15:0]}};
                st_strb = 4'b0011 << ALUResult[1:0];
            end
            default: begin
                st_data = WriteData;
                st_strb = 4'b1111;
            end
        endcase
    end

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [2:0] f,
                                            input logic [1:0] o);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{o, 3'b000} +: 8];
        h = o[1] ? d[31:16] : d[15:0];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return d;
        endcase
    endfunction

    assign Busy = (state == REQ) || (state == WAIT) || (state == IDLE && Start);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            is_load     <= 1'b0;
            f3          <= 3'd0;
            off         <= 2'd0;
            MemReqValid <= 1'b0;
            MemAddr     <= 32'd0;
            MemWe       <= 1'b0;
            MemWData    <= 32'd0;
            MemWStrb    <= 4'd0;
            ReadData    <= 32'd0;
            Done        <= 1'b0;
            Fault       <= 1'b0;
            FaultCause  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    Done       <= 1'b0;
                    Fault      <= 1'b0;
                    FaultCause <= 2'b00;
                    if (Start) begin
                        is_load <= MemRead;
                        f3      <= Funct3;
                        off     <= ALUResult[1:0];
                        if (illegal) begin
                            state      <= DONE;
                            Done       <= 1'b1;
                            Fault      <= 1'b1;
                            FaultCause <= 2'b10;
                        end else if (misaligned) begin
                            state      <= DONE;
                            Done       <= 1'b1;
                            Fault      <= 1'b1;
                            FaultCause <= 2'b01;
                        end else begin
                            state       <= REQ;
                            MemReqValid <= 1'b1;
                            MemAddr     <= {ALUResult[31:2], 2'b00};
                            MemWe       <= MemWrite;
                            MemWData    <= MemWrite ? st_data : 32'd0;
                            MemWStrb    <= MemWrite ? st_strb : 4'd0;
                        end
                    end
                end
                REQ: begin
                    if (MemReqReady) begin
                        MemReqValid <= 1'b0;
                        if (is_load) begin
                            state <= WAIT;
                            cnt   <= 8'd0;
                        end else begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // A response in the final allowed cycle still wins over the timeout.
                    if (MemRspValid) begin
                        ReadData <= extract(MemRData, f3, off);
                        state    <= DONE;
                        Done     <= 1'b1;
                    end else if ((32'(cnt) + 32'd1) >= RSP_TIMEOUT) begin
                        ReadData   <= 32'd0;
                        state      <= DONE;
                        Done       <= 1'b1;
                        Fault      <= 1'b1;
                        FaultCause <= 2'b11;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    Done       <= 1'b0;
                    Fault      <= 1'b0;
                    FaultCause <= 2'b00;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with directed vectors
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start, MemRead, MemWrite, MemReqReady;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData, rsp_val;
    logic        MemReqValid, MemWe, Done, Busy, Fault;
    logic [31:0] MemAddr, MemWData, ReadData;
    logic [3:0]  MemWStrb;
    logic [1:0]  FaultCause;
    logic        resp_pulse = 1'b0;
    logic        late_pulse = 1'b0;
    logic        resp_on;
    wire         MemRspValid = resp_pulse | late_pulse;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    load_store_unit #(.RSP_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .Start(Start), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData),
        .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemAddr(MemAddr),
        .MemWe(MemWe), .MemWData(MemWData), .MemWStrb(MemWStrb),
        .MemRspValid(MemRspValid), .MemRData(rsp_val), .ReadData(ReadData),
        .Done(Done), .Busy(Busy), .Fault(Fault), .FaultCause(FaultCause)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        bit          chk_rd;
        logic        fault;
        logic [1:0]  cause;
        int          start;
        int          lat;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        bit          chk_wd;
    } req_t;

    done_t dq[$];
    req_t  rq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: completion and request handshakes are checked against the queues.
    always @(negedge clk) begin
        done_t e;
        req_t  r;
        if (rst) begin
            if (Done) begin
                if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = dq.pop_front();
                    chk("fault", {31'd0, Fault}, {31'd0, e.fault});
                    chk("fault_cause", {30'd0, FaultCause}, {30'd0, e.cause});
                    chk("busy_in_done", {31'd0, Busy}, 32'd0);
                    if (e.chk_rd) chk("read_data", ReadData, e.rd);
                    if (e.lat != 0) chk("latency", 32'(cyc - e.start), 32'(e.lat));
                end
            end else if (Fault || FaultCause != 2'b00) begin
                chk("fault_outside_done", {29'd0, Fault, FaultCause}, 32'd0);
            end
            if (MemReqValid && MemReqReady) begin
                if (rq.size() == 0) chk("unexpected_request", 32'd1, 32'd0);
                else begin
                    r = rq.pop_front();
                    chk("mem_addr", MemAddr, r.addr);
                    chk("mem_we", {31'd0, MemWe}, {31'd0, r.we});
                    chk("mem_wstrb", {28'd0, MemWStrb}, {28'd0, r.strb});
                    if (r.chk_wd) chk("mem_wdata", MemWData, r.wdata);
                end
            end
        end
    end

    // Memory responder: answers a load handshake on the following cycle.
    always @(negedge clk) begin
        if (rst && MemReqValid && MemReqReady && !MemWe && resp_on) begin
            @(posedge clk);
            #1 resp_pulse = 1'b1;
            @(posedge clk);
            #1 resp_pulse = 1'b0;
        end
    end

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (Done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic rsp, input logic [31:0] rdata,
                      input logic [31:0] exp_rd, input bit chk_rd,
                      input logic fault, input logic [1:0] cause, input int lat,
                      input bit has_req, input logic [31:0] raddr, input logic rwe,
                      input logic [3:0] rstrb, input logic [31:0] rwd, input bit chk_wd);
        done_t e;
        req_t  r;
        @(posedge clk);
        #1;
        resp_on = rsp;
        rsp_val = rdata;
        e = '{rd: exp_rd, chk_rd: chk_rd, fault: fault, cause: cause, start: cyc, lat: lat};
        dq.push_back(e);
        if (has_req) begin
            r = '{addr: raddr, we: rwe, strb: rstrb, wdata: rwd, chk_wd: chk_wd};
            rq.push_back(r);
        end
        Start = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
        ALUResult = addr; WriteData = wd;
        #1 chk("busy_on_start", {31'd0, Busy}, 32'd1);
        @(posedge clk);
        #1 Start = 1'b0;
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        done_t e;
        req_t  r;
        rst = 1'b0; Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0;
        ALUResult = 32'd0; WriteData = 32'd0; rsp_val = 32'd0; MemReqReady = 1'b1;
        resp_on = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'd0, MemReqValid}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_read_data", ReadData, 32'd0);
        chk("rst_mem_addr", MemAddr, 32'd0);
        chk("rst_fault", {29'd0, Fault, FaultCause}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Stores
        op(0, 1, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 32'h0, 1, 0, 2'b00, 2,
           1, 32'h1000, 1, 4'b1000, 32'hA5A5A5A5, 1);
        op(0, 1, 3'b001, 32'h1002, 32'h1234ABCD, 0, 0, 32'h0, 1, 0, 2'b00, 2,
           1, 32'h1000, 1, 4'b1100, 32'hABCDABCD, 1);
        op(0, 1, 3'b010, 32'h1004, 32'hDEADBEEF, 0, 0, 32'h0, 1, 0, 2'b00, 2,
           1, 32'h1004, 1, 4'b1111, 32'hDEADBEEF, 1);
        // Loads
        op(1, 0, 3'b001, 32'h2002, 0, 1, 32'h8001FFFF, 32'hFFFF8001, 1, 0, 2'b00, 3,
           1, 32'h2000, 0, 4'b0000, 0, 0);
        op(1, 0, 3'b101, 32'h2002, 0, 1, 32'h8001FFFF, 32'h00008001, 1, 0, 2'b00, 3,
           1, 32'h2000, 0, 4'b0000, 0, 0);
        op(1, 0, 3'b000, 32'h2003, 0, 1, 32'h8001FFFF, 32'hFFFFFF80, 1, 0, 2'b00, 3,
           1, 32'h2000, 0, 4'b0000, 0, 0);
        op(1, 0, 3'b100, 32'h2003, 0, 1, 32'h8001FFFF, 32'h00000080, 1, 0, 2'b00, 3,
           1, 32'h2000, 0, 4'b0000, 0, 0);
        op(1, 0, 3'b010, 32'h4000, 0, 1, 32'h12345678, 32'h12345678, 1, 0, 2'b00, 3,
           1, 32'h4000, 0, 4'b0000, 0, 0);
        // Faults: no request, Done one cycle after Start, ReadData held
        op(1, 0, 3'b010, 32'h3001, 0, 1, 0, 32'h12345678, 1, 1, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        op(1, 0, 3'b010, 32'h3002, 0, 1, 0, 32'h12345678, 1, 1, 2'b01, 1, 0, 0, 0, 0, 0, 0);
        op(1, 1, 3'b010, 32'h0000, 0, 1, 0, 32'h12345678, 1, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0);
        op(0, 0, 3'b010, 32'h0000, 0, 1, 0, 32'h12345678, 1, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0);
        op(1, 0, 3'b011, 32'h0003, 0, 1, 0, 32'h12345678, 1, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0);
        op(0, 1, 3'b100, 32'h1001, 0, 1, 0, 32'h12345678, 1, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0);
        op(0, 1, 3'b001, 32'h1001, 0, 1, 0, 32'h12345678, 1, 1, 2'b01, 1, 0, 0, 0, 0, 0, 0);

        // Timeout: 4 WAIT cycles with no response
        op(1, 0, 3'b010, 32'h5000, 0, 0, 32'hCAFEF00D, 32'h0, 1, 1, 2'b11, 6,
           1, 32'h5000, 0, 4'b0000, 0, 0);
        @(posedge clk);
        #1 late_pulse = 1'b1;
        repeat (2) @(posedge clk);
        #1 late_pulse = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rsp_no_done", {31'd0, Done}, 32'd0);
        end
        chk("late_rsp_read_data", ReadData, 32'h0);

        // Back-pressure: request fields stable for 5 cycles, second Start ignored
        resp_on = 1'b1;
        @(posedge clk);
        #1;
        MemReqReady = 1'b0;
        e = '{rd: 32'h0, chk_rd: 1, fault: 0, cause: 2'b00, start: cyc, lat: 7};
        dq.push_back(e);
        r = '{addr: 32'h6000, we: 1, strb: 4'b1111, wdata: 32'h11223344, chk_wd: 1};
        rq.push_back(r);
        Start = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b010;
        ALUResult = 32'h6000; WriteData = 32'h11223344;
        @(posedge clk);
        #1 Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, MemReqValid}, 32'd1);
            chk("stall_addr", MemAddr, 32'h6000);
            chk("stall_wdata", MemWData, 32'h11223344);
            chk("stall_strb", {28'd0, MemWStrb}, 32'hF);
            chk("stall_busy", {31'd0, Busy}, 32'd1);
            if (i == 1) begin
                Start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h7000;
            end
            if (i == 2) Start = 1'b0;
        end
        @(posedge clk);
        #1 MemReqReady = 1'b1;
        wait_done();

        op(1, 0, 3'b010, 32'h4000, 0, 1, 32'h12345678, 32'h12345678, 1, 0, 2'b00, 3,
           1, 32'h4000, 0, 4'b0000, 0, 0);

        // Reset asserted while in WAIT
        resp_on = 1'b0;
        @(posedge clk);
        #1;
        r = '{addr: 32'h7000, we: 0, strb: 4'b0000, wdata: 32'h0, chk_wd: 0};
        rq.push_back(r);
        Start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h7000;
        @(posedge clk);
        #1 Start = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("wait_rst_req_valid", {31'd0, MemReqValid}, 32'd0);
        chk("wait_rst_busy", {31'd0, Busy}, 32'd0);
        chk("wait_rst_done", {31'd0, Done}, 32'd0);
        chk("wait_rst_read_data", ReadData, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        late_pulse = 1'b1;
        repeat (2) @(posedge clk);
        #1 late_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", {31'd0, Done}, 32'd0);
        end
        chk("post_rst_read_data", ReadData, 32'd0);

        chk("done_queue_empty", 32'(dq.size()), 32'd0);
        chk("req_queue_empty", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
